// File: rtl/ifetch_if.sv
// Fetch-stage bundle: instruction memory request/grant bus, decode handshake and redirect.
// master = fetch stage, slave = memory/decode/branch environment.
interface ifetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_incr_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_err_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_incr_o, fetch_err_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_incr_o, fetch_err_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, prefetch FIFO and redirect flush.
// Optional IFETCH_MISALIGN_CHK_EN: misaligned redirect targets halt fetch and raise fetch_err_o.
module ifetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic      clk,
    input logic      rst_n,
    ifetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] OUT_LIM   = CW'(MAX_OUTSTANDING);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [31:0]   pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];

    logic        run;
    logic        credit_ok;
    logic        req;
    logic        grant;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic [31:0] rsp_pc;

`ifdef IFETCH_MISALIGN_CHK_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.redirect_i)
            state_next = (bus.redirect_pc_i[1:0] != 2'b00) ? HALT : RUN;
    end

    assign run             = (state_reg == RUN);
    assign bus.fetch_err_o = (state_reg == HALT);
`else
    assign run             = 1'b1;
    assign bus.fetch_err_o = 1'b0;
`endif

    // Credit covers both in-flight requests and buffered entries, so the FIFO can never overflow.
    assign credit_ok  = (outstanding_reg < OUT_LIM) &&
                        (({1'b0, outstanding_reg} + {1'b0, count_reg}) < DEPTH_LIM);
    assign req        = run & ~bus.redirect_i & credit_ok;
    assign grant      = req & bus.imem_gnt_i;
    assign head_valid = (count_reg != '0);
    assign push       = bus.imem_rvalid_i & run & ~bus.redirect_i & (discard_reg == '0);
    assign pop        = head_valid & bus.instr_ready_i & ~bus.redirect_i;

    // With nothing left to discard, every in-flight request is from the current stream,
    // so the oldest one sits 4*outstanding bytes behind the next fetch address.
    assign rsp_pc = fetch_pc_reg - (32'(outstanding_reg) << 2);

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg;
        discard_next     = discard_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;

        case ({grant, bus.imem_rvalid_i})
            2'b10:   outstanding_next = outstanding_reg + CW'(1);
            2'b01:   outstanding_next = outstanding_reg - CW'(1);
            default: outstanding_next = outstanding_reg;
        endcase

        if (bus.redirect_i) begin
            fetch_pc_next = bus.redirect_pc_i & ~32'h3;
            discard_next  = outstanding_next;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
        end else begin
            if (grant)
                fetch_pc_next = fetch_pc_reg + 32'd4;
            if (bus.imem_rvalid_i && (discard_reg != '0))
                discard_next = discard_reg - CW'(1);
            if (push)
                wr_ptr_next = wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_next = rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= {RESET_PC[31:2], 2'b00};
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [31:0] pc_q;
        logic [31:0] instr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pc_q    <= '0;
                instr_q <= '0;
            end else if (push && (wr_ptr_reg == PW'(gi))) begin
                pc_q    <= rsp_pc;
                instr_q <= bus.imem_rdata_i;
            end
        end

        assign pc_mem[gi]    = pc_q;
        assign instr_mem[gi] = instr_q;
    end

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = fetch_pc_reg;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = instr_mem[rd_ptr_reg];
    assign bus.pc_o          = pc_mem[rd_ptr_reg];
    assign bus.pc_incr_o     = pc_mem[rd_ptr_reg] + 32'd4;
endmodule
